// File: rtl/board_pkg.sv
// Shared constants, encodings and types for the board state write path.
package board_pkg;

  localparam int unsigned NUM_SQUARES = 32;
  localparam int unsigned ADDR_W      = 5;
  localparam int unsigned DATA_W      = 8;

  // Icon codes stored in the board state RAM.
  localparam logic [DATA_W-1:0] PIECE_EMPTY      = 8'h00;
  localparam logic [DATA_W-1:0] PIECE_RED_MAN    = 8'h01;
  localparam logic [DATA_W-1:0] PIECE_BLACK_MAN  = 8'h02;
  localparam logic [DATA_W-1:0] PIECE_RED_KING   = 8'h03;
  localparam logic [DATA_W-1:0] PIECE_BLACK_KING = 8'h04;

  // Opening layout: black occupies the top three rows, red the bottom three.
  localparam int unsigned INIT_BLACK_END = 12;
  localparam int unsigned INIT_RED_START = 20;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_MOVE  = 2'b01,
    OP_INIT  = 2'b10,
    OP_CLEAR = 2'b11
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_MV_DST = 3'd2,
    ST_MV_SRC = 3'd3,
    ST_MV_CAP = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  // Command fields captured at acceptance.
  typedef struct packed {
    cmd_op_e             op;
    logic [ADDR_W-1:0]   src;
    logic [ADDR_W-1:0]   dst;
    logic [ADDR_W-1:0]   cap;
    logic                cap_en;
    logic [DATA_W-1:0]   piece;
  } cmd_t;

endpackage

// File: rtl/board_init_layout.sv
// Maps a square index to the piece code it holds in the opening position.
module board_init_layout
  import board_pkg::*;
(
  input  logic [ADDR_W-1:0] square,
  output logic [DATA_W-1:0] piece_c
);

  // Three-band lookup: black men, empty middle, red men.
  always_comb begin
    piece_c = PIECE_EMPTY;
    if (square < ADDR_W'(INIT_BLACK_END)) begin
      piece_c = PIECE_BLACK_MAN;
    end else if (square >= ADDR_W'(INIT_RED_START)) begin
      piece_c = PIECE_RED_MAN;
    end
  end

endmodule

// File: rtl/board_state_sequencer.sv
// Expands whole-board commands into RAM write bursts and arbitrates the
// RAM write port against single-square host writes.
module board_state_sequencer
  import board_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [ADDR_W-1:0] cmd_cap,
  input  logic              cmd_cap_en,
  input  logic [DATA_W-1:0] cmd_piece,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_ack,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              busy,
  output logic              done
);

  state_e            state, state_next;
  cmd_t              cmd_q, cmd_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] init_piece_c;
  logic              accept_c;

  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] din_d;
  logic              ack_d;
  logic              ready_d;
  logic              busy_d;
  logic              done_d;

  assign accept_c = cmd_valid && cmd_ready;

  board_init_layout u_layout (
    .square  (cnt_q),
    .piece_c (init_piece_c)
  );

  // Next-state, next-write and handshake decode.
  always_comb begin
    state_next = state;
    cmd_d      = cmd_q;
    cnt_d      = cnt_q;
    we_d       = 1'b0;
    addr_d     = '0;
    din_d      = '0;
    ack_d      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (accept_c) begin
          cmd_d.op     = cmd_op_e'(cmd_op);
          cmd_d.src    = cmd_src;
          cmd_d.dst    = cmd_dst;
          cmd_d.cap    = cmd_cap;
          cmd_d.cap_en = cmd_cap_en;
          cmd_d.piece  = cmd_piece;
          cnt_d        = '0;
          case (cmd_op)
            OP_NOP:  state_next = ST_DONE;
            OP_MOVE: state_next = ST_MV_DST;
            default: state_next = ST_FILL;
          endcase
        end else if (host_we && !host_ack) begin
          // host_ack blocks a second grant while the host still holds host_we
          we_d   = 1'b1;
          addr_d = host_addr;
          din_d  = host_data;
          ack_d  = 1'b1;
        end
      end

      ST_FILL: begin
        we_d   = 1'b1;
        addr_d = cnt_q;
        din_d  = (cmd_q.op == OP_INIT) ? init_piece_c : PIECE_EMPTY;
        cnt_d  = ADDR_W'(cnt_q + 1'b1);
        if (cnt_q == ADDR_W'(NUM_SQUARES - 1)) begin
          state_next = ST_DONE;
        end
      end

      ST_MV_DST: begin
        we_d       = 1'b1;
        addr_d     = cmd_q.dst;
        din_d      = cmd_q.piece;
        state_next = ST_MV_SRC;
      end

      ST_MV_SRC: begin
        we_d       = 1'b1;
        addr_d     = cmd_q.src;
        din_d      = PIECE_EMPTY;
        state_next = cmd_q.cap_en ? ST_MV_CAP : ST_DONE;
      end

      ST_MV_CAP: begin
        we_d       = 1'b1;
        addr_d     = cmd_q.cap;
        din_d      = PIECE_EMPTY;
        state_next = ST_DONE;
      end

      ST_DONE: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Ready only once IDLE has been held for a full cycle, so it trails done.
    ready_d = (state == ST_IDLE) && (state_next == ST_IDLE);
    busy_d  = (state != ST_IDLE);
    done_d  = (state == ST_DONE);
  end

  // State, command capture and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cmd_q     <= '0;
      cnt_q     <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
      host_ack  <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      cmd_q     <= cmd_d;
      cnt_q     <= cnt_d;
      ram_we    <= we_d;
      ram_addr  <= addr_d;
      ram_din   <= din_d;
      host_ack  <= ack_d;
      cmd_ready <= ready_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule
